// File: rtl/uart_stim_pkg.sv
// uart_stim_pkg: FSM states and parity modes shared by the UART stimulus transmitter.
package uart_stim_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_BREAK} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_stim_fifo.sv
// uart_stim_fifo: synchronous first-word-fall-through FIFO with occupancy count.
module uart_stim_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic w_we, w_re;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_empty = r_wp == r_rp;
    assign o_level = r_wp - r_rp;
    assign o_dout  = r_mem[r_rp[AW-1:0]];
    assign w_we    = i_wr && !o_full;
    assign w_re    = i_rd && !o_empty;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_we) r_wp <= r_wp + 1'b1;
            if (w_re) r_rp <= r_rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (w_we) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/uart_stim_tx.sv
// uart_stim_tx: FIFO-fed UART transmitter driving rx stimulus; tx is registered, idle high.
// Define UART_STIM_BREAK_EN to add the i_brk_req line-break generator (BREAK_BITS low bit times).
module uart_stim_tx
    import uart_stim_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int IDLE_BITS    = 0,
    parameter int FIFO_DEPTH   = 16
`ifdef UART_STIM_BREAK_EN
    , parameter int BREAK_BITS = 12
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [DATA_BITS-1:0]          i_wr_data,
`ifdef UART_STIM_BREAK_EN
    input  logic                          i_brk_req,
`endif
    output logic                          o_full,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);
    state_t r_state, w_nx;
    logic [CW-1:0] r_cnt;
    logic [15:0] r_bit, w_lim;
    logic [DATA_BITS-1:0] r_sr, w_dout;
    logic r_par, r_brk, r_tx, r_ovf;
    logic w_empty, w_pop, w_end, w_last, w_brk_go, w_tx;

`ifdef UART_STIM_BREAK_EN
    assign w_brk_go = i_brk_req;
`else
    assign w_brk_go = 1'b0;
`endif

    uart_stim_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (i_wr_en),
        .i_din   (i_wr_data),
        .i_rd    (w_pop),
        .o_dout  (w_dout),
        .o_full  (o_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_comb begin
        w_lim = '0;
        w_nx  = r_state;
        w_tx  = 1'b1;
        case (r_state)
            S_DATA:  w_lim = 16'(DATA_BITS - 1);
            S_STOP:  w_lim = 16'(STOP_BITS - 1);
            S_GAP:   w_lim = 16'(IDLE_BITS - 1);
`ifdef UART_STIM_BREAK_EN
            S_BREAK: w_lim = 16'(BREAK_BITS - 1);
`endif
            default: w_lim = '0;
        endcase
        w_end  = r_cnt == '0;
        w_last = w_end && (r_bit == w_lim);
        case (r_state)
            S_IDLE:   w_nx = w_brk_go ? S_BREAK : w_empty ? S_IDLE : S_START;
            S_START:  begin w_tx = 1'b0; if (w_end) w_nx = S_DATA; end
            S_DATA:   begin w_tx = r_sr[0]; if (w_last) w_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP; end
            S_PARITY: begin w_tx = r_par; if (w_end) w_nx = S_STOP; end
            S_STOP:   if (w_last) w_nx = (IDLE_BITS != 0 && !r_brk) ? S_GAP : w_empty ? S_IDLE : S_START;
            S_GAP:    if (w_last) w_nx = w_empty ? S_IDLE : S_START;
`ifdef UART_STIM_BREAK_EN
            S_BREAK:  begin w_tx = 1'b0; if (w_last) w_nx = S_STOP; end
`endif
            default:  w_nx = S_IDLE;
        endcase
        // every entry into START is a pop, which also covers back-to-back frames
        w_pop = (w_nx == S_START) && (r_state != S_START);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sr    <= '0;
            r_par   <= 1'b0;
            r_brk   <= 1'b0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nx;
            r_cnt   <= (r_state == S_IDLE || w_end) ? CNT_TOP : r_cnt - 1'b1;
            r_bit   <= (w_nx != r_state) ? '0 : r_bit + 16'(w_end);
            r_sr    <= w_pop ? w_dout : (r_state == S_DATA && w_end) ? r_sr >> 1 : r_sr;
            if (w_pop) r_par <= ^w_dout ^ (PARITY == PAR_ODD);
            r_brk   <= (w_nx == S_BREAK) || (r_brk && w_nx != S_IDLE && w_nx != S_START);
            r_tx    <= w_tx;
            r_ovf   <= i_wr_en && o_full;
        end

    assign o_tx   = r_tx;
    assign o_ovf  = r_ovf;
    assign o_busy = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_uart_stim_tx.sv
// tb_uart_stim_tx: directed checks of framing, back-to-back, FIFO overflow, parity, reset and break.
module tb_uart_stim_tx;
    logic clk = 1'b0, rst = 1'b1;
    logic wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, brk = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic [6:0] d2 = '0;
    logic full0, ovf0, busy0, tx0, full1, ovf1, busy1, tx1, full2, ovf2, busy2, tx2;
    logic [4:0] lvl0, lvl2;
    logic [2:0] lvl1;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_stim_tx u0 (
        .clk(clk), .rst(rst), .i_wr_en(wr0), .i_wr_data(d0),
`ifdef UART_STIM_BREAK_EN
        .i_brk_req(brk),
`endif
        .o_full(full0), .o_ovf(ovf0), .o_level(lvl0), .o_busy(busy0), .o_tx(tx0)
    );
    uart_stim_tx #(.FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .i_wr_en(wr1), .i_wr_data(d1),
`ifdef UART_STIM_BREAK_EN
        .i_brk_req(1'b0),
`endif
        .o_full(full1), .o_ovf(ovf1), .o_level(lvl1), .o_busy(busy1), .o_tx(tx1)
    );
    uart_stim_tx #(.PARITY(2), .DATA_BITS(7), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .i_wr_en(wr2), .i_wr_data(d2),
`ifdef UART_STIM_BREAK_EN
        .i_brk_req(1'b0),
`endif
        .o_full(full2), .o_ovf(ovf2), .o_level(lvl2), .o_busy(busy2), .o_tx(tx2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // 8N1 frame bit b: start, 8 data LSB first, stop
    function automatic logic fbit8(input logic [7:0] w, input int b);
        return (b == 0) ? 1'b0 : (b <= 8) ? w[b-1] : 1'b1;
    endfunction

    initial begin
        logic [7:0] w;
        logic [7:0] q [3];
        logic [7:0] w3 [6];
        logic [10:0] frm;
        logic seen_low;
        tick(3);
        chk("rst_tx", tx0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_busy", busy0, 0);
        rst = 1'b0;
        tick(2);

        // single 0x55 frame, exact start/stop timing
        w = 8'h55;
        wr0 = 1'b1; d0 = w;
        tick(1);
        wr0 = 1'b0;
        chk("t1_level", lvl0, 1);
        chk("t1_busy", busy0, 1);
        tick(1);
        chk("t1_prestart_tx", tx0, 1);
        chk("t1_pop_level", lvl0, 0);
        tick(1);
        chk("t1_start", tx0, 0);
        tick(19);
        chk("t1_start_last", tx0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 ? 1 : 20);
            chk("t1_data", tx0, w[i]);
        end
        tick(20);
        chk("t1_stop", tx0, 1);
        tick(18);
        chk("t1_busy_stop", busy0, 1);
        tick(1);
        chk("t1_busy_done", busy0, 0);
        chk("t1_tx_done", tx0, 1);

        // three back-to-back frames, checked every cycle
        q = '{8'h8E, 8'h04, 8'hEE};
        wr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = q[i];
            tick(1);
        end
        wr0 = 1'b0;
        chk("t2_level", lvl0, 2);
        for (int j = 0; j < 600; j++) begin
            chk("t2_tx", tx0, fbit8(q[j / 200], (j % 200) / 20));
            tick(1);
        end
        chk("t2_busy_end", busy0, 0);
        chk("t2_tx_end", tx0, 1);

        // reset in the middle of the second of three queued frames
        wr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = q[i];
            tick(1);
        end
        wr0 = 1'b0;
        tick(245);
        chk("t5_pre_tx", tx0, 0);
        chk("t5_pre_level", lvl0, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", tx0, 1);
        chk("t5_rst_level", lvl0, 0);
        chk("t5_rst_busy", busy0, 0);
        tick(2);
        rst = 1'b0;
        seen_low = 1'b0;
        for (int j = 0; j < 500; j++) begin
            seen_low |= !tx0;
            tick(1);
        end
        chk("t5_quiet", seen_low, 0);
        chk("t5_busy", busy0, 0);

        // depth-4 FIFO: six pushes, one dropped, five frames
        w3 = '{8'h11, 8'h2C, 8'h3A, 8'hC4, 8'h5F, 8'h66};
        wr1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d1 = w3[i];
            tick(1);
            if (i == 3) begin
                chk("t3_level3", lvl1, 3);
                chk("t3_notfull", full1, 0);
            end
            if (i == 4) begin
                chk("t3_full", full1, 1);
                chk("t3_level4", lvl1, 4);
                chk("t3_no_ovf", ovf1, 0);
            end
        end
        wr1 = 1'b0;
        chk("t3_ovf", ovf1, 1);
        tick(1);
        chk("t3_ovf_once", ovf1, 0);
        for (int j = 4; j < 1000; j++) begin
            chk("t3_tx", tx1, fbit8(w3[j / 200], (j % 200) / 20));
            if (j == 198) chk("t3_level_hold", lvl1, 4);
            if (j == 199) begin
                chk("t3_level_dec", lvl1, 3);
                chk("t3_full_clr", full1, 0);
            end
            tick(1);
        end
        chk("t3_busy_end", busy1, 0);
        chk("t3_level_end", lvl1, 0);
        chk("t3_tx_end", tx1, 1);

        // 7 data bits, odd parity, two stop bits
        frm = {2'b11, 1'b0, 7'h07, 1'b0};
        wr2 = 1'b1; d2 = 7'h07;
        tick(1);
        wr2 = 1'b0;
        tick(2);
        for (int j = 0; j < 220; j++) begin
            chk("t4_tx", tx2, frm[j / 20]);
            if (j == 218) chk("t4_busy_stop", busy2, 1);
            if (j == 219) chk("t4_busy_done", busy2, 0);
            tick(1);
        end
        chk("t4_tx_end", tx2, 1);

`ifdef UART_STIM_BREAK_EN
        // break takes priority over the queued word, then the word follows
        brk = 1'b1; wr0 = 1'b1; d0 = 8'h0C;
        tick(1);
        brk = 1'b0; wr0 = 1'b0;
        chk("t6_tx_first", tx0, 1);
        chk("t6_level", lvl0, 1);
        chk("t6_busy", busy0, 1);
        tick(1);
        for (int j = 0; j < 460; j++) begin
            chk("t6_tx", tx0, (j < 240) ? 1'b0 : (j < 260) ? 1'b1 : fbit8(8'h0C, (j - 260) / 20));
            tick(1);
        end
        chk("t6_busy_end", busy0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
